// File: rtl/layer_sequencer_pkg.sv
// Shared types and helpers for the layer sequencer: FSM state encodings and a
// ceil-log2 used to size the layer index and watchdog counters.
package layer_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int CLOG2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Counters and indices need at least one bit even when the range collapses.
  function automatic int CLOG2_MIN1(input int v);
    return (CLOG2(v) < 1) ? 1 : CLOG2(v);
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Handshake between the sequencer (seq) and the shared layer datapath (dp).
interface layer_sequencer_if #(
  parameter int NEURON_NUM = 6,
  parameter int ACT_WIDTH  = 9,
  parameter int IDX_W      = 2
);
  logic                            layer_start;
  logic [IDX_W-1:0]                layer_idx;
  logic [NEURON_NUM*ACT_WIDTH-1:0] layer_input;
  logic [NEURON_NUM*ACT_WIDTH-1:0] layer_output;
  logic [NEURON_NUM-1:0]           layer_output_valid;

  modport seq (output layer_start, layer_idx, layer_input,
               input  layer_output, layer_output_valid);
  modport dp  (input  layer_start, layer_idx, layer_input,
               output layer_output, layer_output_valid);
endinterface

// File: rtl/layer_result_collector.sv
// Gathers per-lane datapath results that may arrive on different cycles.
// o_buffer already merges same-cycle valids so the caller can consume it on completion.
module layer_result_collector
  import layer_sequencer_pkg::*;
#(
  parameter int NEURON_NUM = 6,
  parameter int ACT_WIDTH  = 9
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_clr,
  input  logic                            i_en,
  input  logic [NEURON_NUM-1:0]           i_valid,
  input  logic [NEURON_NUM*ACT_WIDTH-1:0] i_data,
  output logic [NEURON_NUM*ACT_WIDTH-1:0] o_buffer,
  output logic                            o_complete
);
  logic [NEURON_NUM-1:0]           r_mask;
  logic [NEURON_NUM*ACT_WIDTH-1:0] r_buf;
  logic [NEURON_NUM*ACT_WIDTH-1:0] w_merged;

  for (genvar i = 0; i < NEURON_NUM; i++) begin : g_lane
    assign w_merged[i*ACT_WIDTH +: ACT_WIDTH] =
      i_valid[i] ? i_data[i*ACT_WIDTH +: ACT_WIDTH] : r_buf[i*ACT_WIDTH +: ACT_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
      r_buf  <= '0;
    end else if (i_clr) begin
      r_mask <= '0;
    end else if (i_en) begin
      r_buf  <= w_merged;
      r_mask <= r_mask | i_valid;
    end
  end

  assign o_buffer   = w_merged;
  assign o_complete = i_en & (&(r_mask | i_valid));
endmodule

// File: rtl/layer_sequencer.sv
// Runs one input vector through a shared layer datapath LAYER_NUM times, feeding results back.
// Optional INPUT_QUEUE_EN adds a one-entry input queue so a start can be taken while busy.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int NEURON_NUM     = 6,
  parameter int ACT_WIDTH      = 9,
  parameter int LAYER_NUM      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [NEURON_NUM*ACT_WIDTH-1:0] i_start_input,
  output logic                            o_start_ready,
  output logic                            o_busy,
  output logic [NEURON_NUM*ACT_WIDTH-1:0] o_final_output,
  output logic [NEURON_NUM-1:0]           o_final_output_valid,
  output logic                            o_error,
  layer_sequencer_if.seq                  dp
);
  localparam int NW    = NEURON_NUM * ACT_WIDTH;
  localparam int IDX_W = CLOG2_MIN1(LAYER_NUM);
  localparam int WD_W  = CLOG2_MIN1(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAYER_NUM - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  logic              r_layer_start;
  logic [IDX_W-1:0]  r_layer_idx;
  logic [NW-1:0]     r_layer_input;
  logic [NW-1:0]     r_final_output;
  logic              r_final_valid;
  logic              r_error;
  logic [WD_W-1:0]   r_wd;

  logic              w_complete;
  logic [NW-1:0]     w_buf;
  logic              w_start_ok;
  logic              w_abort;
  logic              w_pend_vld;
  logic [NW-1:0]     w_pend_data;
  logic              w_launch;

  layer_result_collector #(
    .NEURON_NUM (NEURON_NUM),
    .ACT_WIDTH  (ACT_WIDTH)
  ) u_collect (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (r_state == S_ISSUE),
    .i_en       (r_state == S_WAIT),
    .i_valid    (dp.layer_output_valid),
    .i_data     (dp.layer_output),
    .o_buffer   (w_buf),
    .o_complete (w_complete)
  );

  assign w_start_ok = i_start & o_start_ready;
  assign w_abort    = (r_state == S_WAIT) & ~w_complete & (r_wd == WD_LAST);

`ifdef INPUT_QUEUE_EN
  logic          r_q_full;
  logic [NW-1:0] r_q_data;
  assign o_start_ready = ~r_q_full;
  assign w_pend_vld    = r_q_full | w_start_ok;
  assign w_pend_data   = r_q_full ? r_q_data : i_start_input;
`else
  assign o_start_ready = (r_state == S_IDLE);
  assign w_pend_vld    = w_start_ok;
  assign w_pend_data   = i_start_input;
`endif

  // A new vector can begin from IDLE, straight out of DONE, or straight out of an abort.
  assign w_launch = w_pend_vld & ((r_state == S_IDLE) | (r_state == S_DONE) | w_abort);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_layer_start  <= 1'b0;
      r_layer_idx    <= '0;
      r_layer_input  <= '0;
      r_final_output <= '0;
      r_final_valid  <= 1'b0;
      r_error        <= 1'b0;
      r_wd           <= '0;
`ifdef INPUT_QUEUE_EN
      r_q_full       <= 1'b0;
      r_q_data       <= '0;
`endif
    end else begin
      r_layer_start <= 1'b0;
      r_final_valid <= 1'b0;
      r_error       <= 1'b0;
`ifdef INPUT_QUEUE_EN
      if (r_state != S_IDLE && w_start_ok) begin
        r_q_full <= 1'b1;
        r_q_data <= i_start_input;
      end
`endif
      case (r_state)
        S_ISSUE: begin
          r_wd    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_complete) begin
            if (r_layer_idx < LAST_IDX) begin
              r_layer_input <= w_buf;
              r_layer_idx   <= r_layer_idx + 1'b1;
              r_layer_start <= 1'b1;
              r_state       <= S_ISSUE;
            end else begin
              r_final_output <= w_buf;
              r_final_valid  <= 1'b1;
              r_state        <= S_DONE;
            end
          end else if (w_abort) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: ;
      endcase
      // Launch overrides the state-specific next state above.
      if (w_launch) begin
        r_layer_input <= w_pend_data;
        r_layer_idx   <= '0;
        r_layer_start <= 1'b1;
        r_state       <= S_ISSUE;
`ifdef INPUT_QUEUE_EN
        r_q_full      <= 1'b0;
`endif
      end
    end
  end

  assign o_busy               = (r_state != S_IDLE);
  assign o_final_output       = r_final_output;
  assign o_final_output_valid = {NEURON_NUM{r_final_valid}};
  assign o_error              = r_error;
  assign dp.layer_start       = r_layer_start;
  assign dp.layer_idx         = r_layer_idx;
  assign dp.layer_input       = r_layer_input;
endmodule
